gpio_out_sequencer: RTL and testbench
=====================================

Name: gpio_out_sequencer

Overview:
- Sits directly upstream of the user-project GPIO pads (mprj_io[7:0] via io_out/io_oeb) and is fed by the core's memory-mapped store path.
- The core pushes byte patterns into a small FIFO. The block presents each pattern on the pads for a programmable minimum hold time.
- Guarantees that every written value is externally observable, including back-to-back stores such as a 0x01..0x0A, 0xFF, 0x00 sequence.

Parameters:
- DATA_W, 8, pad/pattern width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- HOLD_W, 16, width of hold_cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  sequencer enable; when low, draining pauses and pads are released.
- wr_en  input  1  push request from the core store decoder.
- wr_data  input  DATA_W  pattern to push.
- wr_ready  output  1  FIFO can accept a push this cycle.
- hold_cycles  input  HOLD_W  minimum cycles each pattern is displayed.
- oe_mask  input  DATA_W  1 = pin driven as output.
- io_out  output  DATA_W  registered pad data.
- io_oeb  output  DATA_W  registered active-low pad output enable.
- busy  output  1  a pattern's hold window is in progress.
- fifo_count  output  $clog2(DEPTH+1)  entries currently queued.
- overflow  output  1  sticky; set when wr_en is high while wr_ready is low.

Behaviour:
- Reset values (rst high at a clk edge): io_out=0, io_oeb=all 1s, busy=0, fifo_count=0, overflow=0, FIFO pointers=0, hold counter=0, state=IDLE. Reset overrides all other inputs in the same cycle.
- wr_ready = (fifo_count != DEPTH). It is combinational from the count only, so a same-cycle pop never frees space for a push.
- Push accepted when wr_en && wr_ready. The entry is written at the edge and counted in fifo_count after that edge.
- Pointers wrap modulo DEPTH. A simultaneous push and pop leaves fifo_count unchanged.
- Effective hold H = max(hold_cycles, 1). hold_cycles is sampled at each pop.
- io_oeb is registered each cycle:
  - = ~oe_mask when en=1;
  - = all 1s when en=0.
- State machine, IDLE:
  - busy=0.
  - If en && fifo_count!=0: pop the head, io_out <= head, counter <= H-1, go HOLD.
  - Latency: a push at edge N into an empty FIFO while IDLE appears on io_out at edge N+1.
- State machine, HOLD:
  - busy=1.
  - If en=0: counter and io_out freeze.
  - Else if counter!=0: counter decrements.
  - Else if fifo_count!=0: pop the next entry immediately (no gap cycle), io_out <= head, counter <= H-1, stay in HOLD.
  - Else go IDLE; io_out retains its value.
- Resulting timing: each pattern stays on io_out for exactly H enabled cycles when the next entry is already queued.
- en deasserted: pushes are still accepted. No pops occur and the hold counter does not advance.
- Full FIFO: a push with wr_en=1 is dropped, existing contents are unchanged, and overflow sets. overflow clears only on rst.
- Reset mid-HOLD: all state is cleared and the queued entries are discarded.

Optional Feature:
- Macro: GPIO_SEQ_IDLE_ZERO_EN.
- Defined: on the HOLD->IDLE transition (hold expired, FIFO empty), io_out <= 0 on that same edge.
- Undefined: the last pattern is held on io_out indefinitely in IDLE.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert rst for 2 cycles with wr_en=1 -> io_out=00, io_oeb=FF, wr_ready=1, fifo_count=0, overflow=0, no entry queued.
- Single push:
  - Setup: en=1, oe_mask=FF, hold_cycles=4; push 0x01 at edge N.
  - Required: io_out=01 and io_oeb=00 from N+1; busy=1 for 4 cycles, then 0.
  - io_out stays 01 (becomes 00 with GPIO_SEQ_IDLE_ZERO_EN).
- Back-to-back burst:
  - Setup: hold_cycles=3; push 01,02,03,04 on consecutive cycles.
  - Required: io_out shows 01,02,03,04 for exactly 3 cycles each with no gaps; fifo_count peaks at 3; overflow=0.
- Overflow while paused:
  - Setup: en=0; push 0A,0B,0C,0D,0E.
  - Required: wr_ready=0 after the 4th push, fifo_count=4, overflow=1, io_oeb=FF.
  - Then en=1 -> io_out drains 0A..0D; 0E is never seen.
- Zero hold: hold_cycles=0; push FF then 00 -> io_out=FF for exactly 1 cycle, then 00.
- Reset mid-operation: rst asserted during the 2nd cycle of a hold with 2 entries queued -> next cycle io_out=00, busy=0, fifo_count=0, overflow=0.

Source files
------------

// File: rtl/gpio_out_sequencer.sv
// gpio_out_sequencer: queues byte patterns from the core store path and
// replays each one on the user-project GPIO pads for a programmable minimum
// hold time, so every stored value is externally observable.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   en           sequencer enable; low pauses draining and releases the pads
//   wr_en        push request from the core store decoder
//   wr_data      pattern to push
//   wr_ready     FIFO can accept a push this cycle (combinational from count)
//   hold_cycles  minimum cycles each pattern is displayed (0 treated as 1)
//   oe_mask      1 = pin driven as output
//   io_out       registered pad data
//   io_oeb       registered active-low pad output enable
//   busy         a pattern's hold window is in progress
//   fifo_count   entries currently queued
//   overflow     sticky; a push was attempted while the FIFO was full
//
// Build option: define GPIO_SEQ_IDLE_ZERO_EN to drive io_out to zero when
// the last hold expires with nothing queued; otherwise the last pattern stays.

module gpio_out_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned HOLD_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_ready,
  input  logic [HOLD_W-1:0]            hold_cycles,
  input  logic [DATA_W-1:0]            oe_mask,
  output logic [DATA_W-1:0]            io_out,
  output logic [DATA_W-1:0]            io_oeb,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [HOLD_W-1:0]   hold_reload;
  logic [DATA_W-1:0]   io_out_nxt;
  logic [DATA_W-1:0]   head;
  logic                push, pop;

  // Space is judged from the registered count only; a same-cycle pop never frees a slot.
  assign wr_ready    = (fifo_count != CNT_W'(DEPTH));
  assign push        = wr_en && wr_ready;
  assign head        = mem[rd_ptr];
  // Effective hold is max(hold_cycles, 1); the counter is loaded with hold-1.
  assign hold_reload = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);

  // Next-state, pop decision and next pad data.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    hold_cnt_nxt = hold_cnt;
    io_out_nxt   = io_out;
    case (state)
      IDLE: begin
        if (en && (fifo_count != '0)) begin
          pop          = 1'b1;
          io_out_nxt   = head;
          hold_cnt_nxt = hold_reload;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (en) begin
          if (hold_cnt != '0) begin
            hold_cnt_nxt = hold_cnt - HOLD_W'(1);
          end else if (fifo_count != '0) begin
            // Chain straight into the next pattern with no gap cycle.
            pop          = 1'b1;
            io_out_nxt   = head;
            hold_cnt_nxt = hold_reload;
          end else begin
            state_nxt = IDLE;
`ifdef GPIO_SEQ_IDLE_ZERO_EN
            io_out_nxt = '0;
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      io_out     <= '0;
      io_oeb     <= '1;
      busy       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      io_out   <= io_out_nxt;
      io_oeb   <= en ? ~oe_mask : '1;
      busy     <= (state_nxt == HOLD);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (wr_en && !wr_ready) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_gpio_out_sequencer.sv
// Directed self-checking bench for gpio_out_sequencer: reset, single push,
// back-to-back burst, overflow while paused, pause freeze, zero hold and
// reset in the middle of a hold.

module tb_gpio_out_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned HOLD_W = 16;

`ifdef GPIO_SEQ_IDLE_ZERO_EN
  localparam bit IDLE_ZERO = 1'b1;
`else
  localparam bit IDLE_ZERO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [HOLD_W-1:0] hold_cycles;
  logic [DATA_W-1:0] oe_mask;
  logic [DATA_W-1:0] io_out;
  logic [DATA_W-1:0] io_oeb;
  logic              busy;
  logic [2:0]        fifo_count;
  logic              overflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  gpio_out_sequencer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .HOLD_W(HOLD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .hold_cycles(hold_cycles),
    .oe_mask    (oe_mask),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_v;

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    wr_en       = 1'b1;
    wr_data     = 8'h55;
    hold_cycles = 16'd4;
    oe_mask     = 8'hFF;

    // Reset held for two edges with a push request present.
    step();
    step();
    chk("rst_io_out", 32'(io_out), 32'h00);
    chk("rst_io_oeb", 32'(io_oeb), 32'hFF);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    rst   = 1'b0;
    wr_en = 1'b0;
    en    = 1'b1;
    step();
    chk("en_io_oeb", 32'(io_oeb), 32'h00);
    chk("idle_count", 32'(fifo_count), 32'h0);

    // Single push, hold 4.
    wr_en   = 1'b1;
    wr_data = 8'h01;
    step();
    wr_en = 1'b0;
    chk("sp_count_push", 32'(fifo_count), 32'h1);
    chk("sp_busy_push", 32'(busy), 32'h0);
    step();
    chk("sp_io_out_n1", 32'(io_out), 32'h01);
    chk("sp_busy_n1", 32'(busy), 32'h1);
    chk("sp_count_n1", 32'(fifo_count), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sp_busy_hold", 32'(busy), 32'h1);
      chk("sp_io_out_hold", 32'(io_out), 32'h01);
    end
    step();
    chk("sp_busy_end", 32'(busy), 32'h0);
    exp_v = IDLE_ZERO ? 8'h00 : 8'h01;
    chk("sp_io_out_idle", 32'(io_out), 32'(exp_v));

    // Back-to-back burst, hold 3.
    hold_cycles = 16'd3;
    wr_en   = 1'b1;
    wr_data = 8'h01;
    step();
    chk("bb_count0", 32'(fifo_count), 32'h1);
    wr_data = 8'h02;
    step();
    chk("bb_count1", 32'(fifo_count), 32'h1);
    chk("bb_out1", 32'(io_out), 32'h01);
    wr_data = 8'h03;
    step();
    chk("bb_count2", 32'(fifo_count), 32'h2);
    chk("bb_out2", 32'(io_out), 32'h01);
    wr_data = 8'h04;
    step();
    wr_en = 1'b0;
    chk("bb_count_peak", 32'(fifo_count), 32'h3);
    chk("bb_out3", 32'(io_out), 32'h01);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("bb_out_seq", 32'(io_out), 32'(2 + i / 3));
      chk("bb_busy_seq", 32'(busy), 32'h1);
    end
    step();
    chk("bb_busy_end", 32'(busy), 32'h0);
    exp_v = IDLE_ZERO ? 8'h00 : 8'h04;
    chk("bb_io_out_idle", 32'(io_out), 32'(exp_v));
    chk("bb_overflow", 32'(overflow), 32'h0);

    // Overflow while paused.
    en    = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h0A + i);
      step();
      if (i == 3) begin
        chk("ov_ready_full", 32'(wr_ready), 32'h0);
        chk("ov_count_full", 32'(fifo_count), 32'h4);
        chk("ov_overflow_pre", 32'(overflow), 32'h0);
      end
    end
    wr_en = 1'b0;
    chk("ov_count", 32'(fifo_count), 32'h4);
    chk("ov_overflow", 32'(overflow), 32'h1);
    chk("ov_io_oeb", 32'(io_oeb), 32'hFF);
    chk("ov_busy", 32'(busy), 32'h0);
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("ov_drain", 32'(io_out), 32'(8'h0A + i / 3));
    end
    step();
    chk("ov_busy_end", 32'(busy), 32'h0);
    exp_v = IDLE_ZERO ? 8'h00 : 8'h0D;
    chk("ov_idle_no_0e", 32'(io_out), 32'(exp_v));
    chk("ov_sticky", 32'(overflow), 32'h1);
    chk("ov_count_end", 32'(fifo_count), 32'h0);

    // Pause mid-hold freezes the counter and the pads are released.
    hold_cycles = 16'd2;
    oe_mask     = 8'h0F;
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    step();
    chk("pz_out", 32'(io_out), 32'h5A);
    chk("pz_oeb_en", 32'(io_oeb), 32'hF0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pz_busy_frozen", 32'(busy), 32'h1);
      chk("pz_oeb_off", 32'(io_oeb), 32'hFF);
    end
    en = 1'b1;
    step();
    chk("pz_busy_last", 32'(busy), 32'h1);
    chk("pz_out_last", 32'(io_out), 32'h5A);
    step();
    chk("pz_busy_end", 32'(busy), 32'h0);
    oe_mask = 8'hFF;

    // Zero hold acts as one cycle.
    hold_cycles = 16'd0;
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    step();
    wr_data = 8'h00;
    step();
    wr_en = 1'b0;
    chk("zh_out_ff", 32'(io_out), 32'hFF);
    chk("zh_count", 32'(fifo_count), 32'h1);
    step();
    chk("zh_out_00", 32'(io_out), 32'h00);
    chk("zh_busy", 32'(busy), 32'h1);
    step();
    chk("zh_busy_end", 32'(busy), 32'h0);
    chk("zh_out_idle", 32'(io_out), 32'h00);

    // Reset in the 2nd cycle of a hold with 2 entries queued.
    hold_cycles = 16'd4;
    wr_en   = 1'b1;
    wr_data = 8'h11;
    step();
    wr_data = 8'h22;
    step();
    wr_data = 8'h33;
    step();
    wr_en = 1'b0;
    chk("rm_count_pre", 32'(fifo_count), 32'h2);
    chk("rm_out_pre", 32'(io_out), 32'h11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_io_out", 32'(io_out), 32'h00);
    chk("rm_busy", 32'(busy), 32'h0);
    chk("rm_count", 32'(fifo_count), 32'h0);
    chk("rm_overflow", 32'(overflow), 32'h0);
    chk("rm_io_oeb", 32'(io_oeb), 32'hFF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rm_quiet_out", 32'(io_out), 32'h00);
      chk("rm_quiet_busy", 32'(busy), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
